mem_master: RTL and testbench

Bus-master front end for `memory_top`: accepts byte or 16-bit word access requests from the 6502 core over a valid/ready handshake and sequences them into single-byte `rd_enable`/`wr_enable` transactions against the memory controller. It waits on `busy`, assembles little-endian words, applies optional 6502 page-wrap addressing, and guards each byte transaction with a timeout. It sits between the CPU core and `memory_top`, as the initiator for the controller's request/busy interface.

---
 rtl/mem_master.sv | 159 +++++++++++++++
 tb/tb_mem_master.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_master.sv
// Bus-master front end: turns byte/word CPU requests into single-byte strobes
// against memory_top, assembling little-endian words with a per-byte timeout.
module mem_master #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic                    req_word,
    input  logic                    req_page_wrap,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic                    rsp_valid,
    output logic [2*DATA_WIDTH-1:0] rsp_rdata,
    output logic                    rsp_error,
    output logic                    mem_rd_enable,
    output logic                    mem_wr_enable,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wr_data,
    input  logic                    mem_busy,
    input  logic [DATA_WIDTH-1:0]   mem_rd_data
);

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]              state_q, state_d;
    logic                    write_q, write_d;
    logic                    word_q, word_d;
    logic                    wrap_q, wrap_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [2*DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                    idx_q, idx_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic [2*DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                    error_q, error_d;

    logic [ADDR_WIDTH-1:0]   next_addr;
    logic [ADDR_WIDTH-1:0]   byte_addr;
    logic                    strobe;
    logic                    timed_out;

    // 6502 page wrap keeps the high byte and lets only the low byte roll over.
    assign next_addr = wrap_q ? {addr_q[ADDR_WIDTH-1:8], addr_q[7:0] + 8'd1}
                              : addr_q + ADDR_WIDTH'(1);
    assign byte_addr = idx_q ? next_addr : addr_q;
    assign strobe    = (state_q == S_ISSUE) && !mem_busy;
    assign timed_out = mem_busy && (timer_q == TW'(TIMEOUT));

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        write_d = write_q;
        word_d  = word_q;
        wrap_d  = wrap_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        rdata_d = rdata_q;
        error_d = error_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    word_d  = req_word;
                    wrap_d  = req_page_wrap;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    idx_d   = 1'b0;
                    timer_d = '0;
                    rdata_d = '0;
                    error_d = 1'b0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!mem_busy) begin
                    timer_d = '0;
                    state_d = S_WAIT;
                end else if (timed_out) begin
                    error_d = 1'b1;
                    state_d = S_RESP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_WAIT: begin
                if (!mem_busy) begin
                    if (!write_q) begin
                        if (idx_q) rdata_d[2*DATA_WIDTH-1:DATA_WIDTH] = mem_rd_data;
                        else       rdata_d[DATA_WIDTH-1:0]            = mem_rd_data;
                    end
                    if (word_q && !idx_q) begin
                        idx_d   = 1'b1;
                        timer_d = '0;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_RESP;
                    end
                end else if (timed_out) begin
                    error_d = 1'b1;
                    state_d = S_RESP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            write_q <= 1'b0;
            word_q  <= 1'b0;
            wrap_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            idx_q   <= 1'b0;
            timer_q <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            word_q  <= word_d;
            wrap_q  <= wrap_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    // Strobes are decoded from state so an async reset removes them at once.
    assign req_ready     = (state_q == S_IDLE);
    assign rsp_valid     = (state_q == S_RESP);
    assign rsp_rdata     = rdata_q;
    assign rsp_error     = error_q;
    assign mem_rd_enable = strobe && !write_q;
    assign mem_wr_enable = strobe && write_q;
    assign mem_addr      = strobe ? byte_addr : '0;
    assign mem_wr_data   = (strobe && write_q)
                         ? (idx_q ? wdata_q[2*DATA_WIDTH-1:DATA_WIDTH] : wdata_q[DATA_WIDTH-1:0])
                         : '0;

endmodule

// File: tb/tb_mem_master.sv
// Directed self-checking bench for mem_master with a busy/latency memory model.
module tb_mem_master;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_word;
    logic        req_page_wrap;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_error;
    logic        mem_rd_enable;
    logic        mem_wr_enable;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wr_data;
    logic        mem_busy;
    logic [7:0]  mem_rd_data;

    mem_master #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_word(req_word), .req_page_wrap(req_page_wrap), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .mem_rd_enable(mem_rd_enable), .mem_wr_enable(mem_wr_enable),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_busy(mem_busy),
        .mem_rd_data(mem_rd_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int busy_n = 0;
    int busy_cnt = 0;
    int both_hi = 0;

    // Memory model: busy for busy_n cycles after each strobe; optional stuck-busy
    // once the first byte has completed (stick_arm).
    logic [7:0]  mem [0:65535];
    logic [7:0]  rd_data_q = 8'h00;
    logic        stick_arm = 1'b0;
    logic        stuck = 1'b0;
    logic        strobe_seen = 1'b0;
    logic        pl_en = 1'b0;
    logic [15:0] pl_addr = 16'h0;
    logic [7:0]  pl_data = 8'h0;

    assign mem_busy    = (busy_cnt != 0) || stuck;
    assign mem_rd_data = rd_data_q;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_wr_enable) mem[mem_addr] <= mem_wr_data;
        if (mem_rd_enable) rd_data_q <= mem[mem_addr];
        if (mem_rd_enable || mem_wr_enable) busy_cnt <= busy_n;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
        if (!stick_arm) begin
            stuck       <= 1'b0;
            strobe_seen <= 1'b0;
        end else if (mem_rd_enable || mem_wr_enable) begin
            strobe_seen <= 1'b1;
        end else if (strobe_seen && busy_cnt == 0) begin
            stuck <= 1'b1;
        end
    end

    logic [15:0] s_addr[$];
    logic [7:0]  s_data[$];
    logic        s_wr[$];

    always @(negedge clk) begin
        if (mem_rd_enable && mem_wr_enable) both_hi <= both_hi + 1;
        if (mem_rd_enable || mem_wr_enable) begin
            s_addr.push_back(mem_addr);
            s_data.push_back(mem_wr_data);
            s_wr.push_back(mem_wr_enable);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge of cycle 1 (accept edge = cycle 0).
    task automatic issue_req(input logic wr, input logic wd, input logic pw,
                             input logic [15:0] a, input logic [15:0] d);
        int k;
        s_addr.delete();
        s_data.delete();
        s_wr.delete();
        req_write     = wr;
        req_word      = wd;
        req_page_wrap = pw;
        req_addr      = a;
        req_wdata     = d;
        k = 0;
        while (!req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("ready_before_accept", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        acc_cyc   = cyc - 1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        int k;
        k = 0;
        while (!rsp_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("rsp_seen", {31'd0, rsp_valid}, 32'd1);
        lat = cyc - acc_cyc;
    endtask

    initial begin
        int lat;
        int k;
        int rsp_cnt;
        int ready_hi;

        reset = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_word = 1'b0;
        req_page_wrap = 1'b0;
        req_addr = 16'h0;
        req_wdata = 16'h0;

        // Reset state plus memory preload while the DUT is held in reset.
        @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_error", {31'd0, rsp_error}, 32'd0);
        check("rst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
        check("rst_strobes", {30'd0, mem_rd_enable, mem_wr_enable}, 32'd0);
        check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        check("rst_mem_wr_data", {24'd0, mem_wr_data}, 32'd0);
        poke(16'h0200, 8'hA5);
        poke(16'h12FF, 8'h34);
        poke(16'h1200, 8'h56);
        poke(16'h1300, 8'h99);
        poke(16'h0400, 8'h3C);
        poke(16'h0401, 8'h77);
        poke(16'h0500, 8'h5A);
        reset = 1'b1;
        @(negedge clk);

        // Byte read, busy for 2 cycles.
        busy_n = 2;
        issue_req(1'b0, 1'b0, 1'b0, 16'h0200, 16'h0000);
        wait_rsp(lat);
        check("br_latency", lat, 32'd5);
        check("br_rdata", {16'd0, rsp_rdata}, 32'h00A5);
        check("br_error", {31'd0, rsp_error}, 32'd0);
        check("br_ready_in_resp", {31'd0, req_ready}, 32'd0);
        check("br_nstrobe", s_addr.size(), 32'd1);
        check("br_addr", {16'd0, s_addr[0]}, 32'h0200);
        check("br_is_read", {31'd0, s_wr[0]}, 32'd0);
        @(negedge clk);
        check("br_rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
        check("br_rdata_held", {16'd0, rsp_rdata}, 32'h00A5);

        // Word write across the address-space wrap, no busy.
        busy_n = 0;
        issue_req(1'b1, 1'b1, 1'b0, 16'hFFFF, 16'hBEEF);
        wait_rsp(lat);
        check("ww_latency", lat, 32'd5);
        check("ww_nstrobe", s_addr.size(), 32'd2);
        check("ww_addr0", {16'd0, s_addr[0]}, 32'hFFFF);
        check("ww_data0", {24'd0, s_data[0]}, 32'h00EF);
        check("ww_addr1", {16'd0, s_addr[1]}, 32'h0000);
        check("ww_data1", {24'd0, s_data[1]}, 32'h00BE);
        check("ww_is_write", {30'd0, s_wr[0], s_wr[1]}, 32'd3);
        check("ww_error", {31'd0, rsp_error}, 32'd0);
        @(negedge clk);

        // Word read with 6502 page wrap, busy 1 cycle per byte.
        busy_n = 1;
        issue_req(1'b0, 1'b1, 1'b1, 16'h12FF, 16'h0000);
        wait_rsp(lat);
        check("wr_latency", lat, 32'd7);
        check("wr_rdata", {16'd0, rsp_rdata}, 32'h5634);
        check("wr_nstrobe", s_addr.size(), 32'd2);
        check("wr_addr1", {16'd0, s_addr[1]}, 32'h1200);
        @(negedge clk);

        // Byte write: upper data byte ignored, read data cleared on accept.
        busy_n = 0;
        issue_req(1'b1, 1'b0, 1'b0, 16'h0300, 16'h7711);
        wait_rsp(lat);
        check("bw_latency", lat, 32'd3);
        check("bw_nstrobe", s_addr.size(), 32'd1);
        check("bw_data", {24'd0, s_data[0]}, 32'h0011);
        check("bw_rdata", {16'd0, rsp_rdata}, 32'h0000);
        @(negedge clk);

        // Busy sticks after the first byte of a word read: timeout after 9 stalled cycles.
        busy_n = 1;
        stick_arm = 1'b1;
        issue_req(1'b0, 1'b1, 1'b0, 16'h0400, 16'h0000);
        wait_rsp(lat);
        check("to_latency", lat, 32'd13);
        check("to_error", {31'd0, rsp_error}, 32'd1);
        check("to_rdata", {16'd0, rsp_rdata}, 32'h003C);
        check("to_nstrobe", s_addr.size(), 32'd1);

        // Next request must stall its strobe until busy falls.
        busy_n = 0;
        issue_req(1'b0, 1'b0, 1'b0, 16'h0500, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        check("stall_no_strobe", s_addr.size(), 32'd0);
        stick_arm = 1'b0;
        wait_rsp(lat);
        check("stall_latency", lat, 32'd6);
        check("stall_error", {31'd0, rsp_error}, 32'd0);
        check("stall_rdata", {16'd0, rsp_rdata}, 32'h005A);
        check("stall_nstrobe", s_addr.size(), 32'd1);
        check("stall_addr", {16'd0, s_addr[0]}, 32'h0500);
        @(negedge clk);

        // Reset pulsed in WAIT: request is lost, no response.
        busy_n = 5;
        issue_req(1'b0, 1'b0, 1'b0, 16'h0200, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_strobes", {30'd0, mem_rd_enable, mem_wr_enable}, 32'd0);
        check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("mid_rst_rdata", {16'd0, rsp_rdata}, 32'h0000);
        @(negedge clk);
        reset = 1'b1;
        rsp_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid) rsp_cnt++;
        end
        check("mid_rst_no_rsp", rsp_cnt, 32'd0);
        busy_n = 0;
        issue_req(1'b0, 1'b0, 1'b0, 16'h0200, 16'h0000);
        wait_rsp(lat);
        check("post_rst_latency", lat, 32'd3);
        check("post_rst_rdata", {16'd0, rsp_rdata}, 32'h00A5);
        @(negedge clk);

        // Back-to-back requests with req_valid held high.
        busy_n = 0;
        s_addr.delete();
        s_data.delete();
        s_wr.delete();
        ready_hi = 0;
        req_write = 1'b0;
        req_word = 1'b0;
        req_page_wrap = 1'b0;
        req_addr = 16'h0200;
        req_valid = 1'b1;
        check("b2b_ready_idle", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        acc_cyc = cyc - 1;
        req_word = 1'b1;
        req_addr = 16'h12FF;
        k = 0;
        while (!rsp_valid && k < 50) begin
            if (req_ready) ready_hi++;
            @(negedge clk);
            k++;
        end
        check("b2b_a_rsp_seen", {31'd0, rsp_valid}, 32'd1);
        check("b2b_a_latency", cyc - acc_cyc, 32'd3);
        check("b2b_a_rdata", {16'd0, rsp_rdata}, 32'h00A5);
        check("b2b_ready_resp", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        check("b2b_ready_after_resp", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        acc_cyc = cyc - 1;
        req_valid = 1'b0;
        k = 0;
        while (!rsp_valid && k < 50) begin
            if (req_ready) ready_hi++;
            @(negedge clk);
            k++;
        end
        check("b2b_b_rsp_seen", {31'd0, rsp_valid}, 32'd1);
        check("b2b_b_latency", cyc - acc_cyc, 32'd5);
        check("b2b_b_rdata", {16'd0, rsp_rdata}, 32'h9934);
        check("b2b_ready_low_busy", ready_hi, 32'd0);
        check("b2b_nstrobe", s_addr.size(), 32'd3);
        check("b2b_addr1", {16'd0, s_addr[1]}, 32'h12FF);
        check("b2b_addr2", {16'd0, s_addr[2]}, 32'h1300);
        @(negedge clk);

        check("strobes_never_both", both_hi, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
